stream_mux_rr: RTL
==================

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter WIDTH, default 4, data width per channel in bits.
REQ-002 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter SW = clog2(N), derived; width of sel and out_sel.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 mode  input  1  0 = fixed select by sel; 1 = round-robin arbitration.
REQ-007 sel  input  SW  channel select used in mode 0.
REQ-008 in_valid  input  N  per-channel beat valid.
REQ-009 in_last  input  N  per-channel end-of-packet marker, qualified by in_valid.
REQ-010 data_in  input  N*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-011 in_ready  output  N  per-channel beat accept.
REQ-012 data_out  output  WIDTH  registered output data.
REQ-013 out_valid  output  1  data_out holds a valid beat.
REQ-014 out_last  output  1  registered end-of-packet for the beat on data_out.
REQ-015 out_ready  input  1  downstream accept.
REQ-016 out_sel  output  SW  channel index of the beat on data_out.
REQ-017 pkt_count  output  16  count of packets fully accepted from inputs; wraps 0xFFFF -> 0x0000.

Function
REQ-018 State machine SHALL have two states: IDLE (no grant) and LOCK (grant held on channel g).
REQ-019 IDLE, mode 0: if sel < N and in_valid[sel], g <= sel, go to LOCK; if sel >= N or no valid on sel, stay IDLE.
REQ-020 IDLE, mode 1: g <= first channel with in_valid set, searching ptr+1, ptr+2, ... wrapping modulo N; go to LOCK; no valid anywhere -> stay IDLE.
REQ-021 No beat SHALL be accepted in IDLE; all in_ready SHALL be 0 in IDLE.
REQ-022 LOCK: in_ready[i] = (i == g) && (!out_valid || out_ready), combinational; all other in_ready bits 0.
REQ-023 Accept = in_valid[g] && in_ready[g]; on accept: data_out <= data_in[g], out_last <= in_last[g], out_sel <= g, out_valid <= 1.
REQ-024 out_ready && out_valid with no accept in the same cycle: out_valid <= 0; data_out, out_last, and out_sel hold.
REQ-025 Simultaneous drain and accept SHALL overwrite the output register with no bubble (full throughput within a packet).
REQ-026 out_valid high with out_ready low: data_out, out_last, and out_sel SHALL hold stable.
REQ-027 Accept with in_last[g] = 1: state <= IDLE, ptr <= g, pkt_count <= pkt_count + 1.
REQ-028 mode and sel changes during LOCK SHALL be ignored until the state returns to IDLE.
REQ-029 Latency: valid first beat seen in IDLE at cycle t -> grant at t+1 -> out_valid at t+2; subsequent beats have 1-cycle latency.
REQ-030 There SHALL be exactly one idle arbitration cycle between consecutive packets.
REQ-031 Single-beat packet (in_last on the first beat) SHALL be legal and behave per REQ-027.
REQ-032 Deasserting in_valid[g] during LOCK SHALL keep the grant; no other channel may be served until its last beat.

Reset
REQ-033 While rst_n = 0: state IDLE, g = 0, ptr = N-1, out_valid = 0, out_last = 0, data_out = 0, out_sel = 0, pkt_count = 0, and in_ready = 0.
REQ-034 Reset asserted mid-packet SHALL discard the partial packet and any beat in the output register; pkt_count SHALL not be incremented.
REQ-035 After rst_n deasserts, the first round-robin search SHALL start at channel 0.

Verification (WIDTH=4, N=4)
REQ-036 mode 0, sel=2, ch2 sends 0x5,0xA(last), out_ready=1 -> data_out 0x5 then 0xA, out_sel=2, out_last on 0xA only, pkt_count=1.
REQ-037 mode 1, all channels valid with 1-beat packets 0x0/0xF/0x5/0xA, out_ready=1 -> out_sel order 0,1,2,3,0 with one idle cycle between beats.
REQ-038 mode 1, ch1 sends a 3-beat packet while ch3 is valid throughout -> all 3 ch1 beats appear before any ch3 beat; in_ready[3]=0 during the ch1 packet.
REQ-039 out_ready held low for 5 cycles mid-packet -> out_valid=1 with data_out stable; in_ready[g]=0; stream resumes with no loss or duplication.
REQ-040 mode 0, sel=3 with only ch0 valid -> stays IDLE, in_ready=0; switch sel to 0 -> ch0 granted the next cycle.
REQ-041 rst_n pulsed low after 2nd of 4 beats -> all outputs at reset values; pkt_count=0; next packet arbitrates from channel 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// Packet-aware stream multiplexer. N input channels share one registered
// output. A channel is granted in IDLE (fixed select or round-robin) and keeps
// the grant until its last beat is accepted. The output stage is a single
// register that can be drained and refilled in the same cycle.
module stream_mux_rr #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SW-1:0]      sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  input  logic [N*WIDTH-1:0] data_in,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic [SW-1:0]      out_sel,
  output logic [15:0]        pkt_count
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    g_q, g_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [SW-1:0]    out_sel_q, out_sel_d;
  logic [15:0]      pkt_q, pkt_d;

  logic [N-1:0]     grant_oh;
  logic [WIDTH-1:0] g_data;
  logic             g_last;
  logic             fix_ok;
  logic             rr_found;
  logic [SW-1:0]    rr_pick;
  int               rr_dist;
  int               rr_best;
  logic             out_free;
  logic             accept;

  // Decode the held grant and pick out that channel's beat.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_oh = '0;
    g_data   = '0;
    g_last   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (int'(g_q) == i) begin
        grant_oh[i] = 1'b1;
        g_data      = data_in[i*WIDTH +: WIDTH];
        g_last      = in_last[i];
      end
    end
  end

  // Fixed-select request check; a sel at or beyond N never matches a channel.
  always_comb begin
    fix_ok = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (int'(sel) == i && in_valid[i]) fix_ok = 1'b1;
    end
  end

  // Round-robin pick: nearest valid channel after ptr, distance measured mod N.
  always_comb begin
    rr_best = N;
    rr_dist = 0;
    rr_pick = '0;
    for (int i = 0; i < N; i++) begin
      rr_dist = (i - int'(ptr_q) - 1 + 2 * N) % N;
      if (in_valid[i] && rr_dist < rr_best) begin
        rr_best = rr_dist;
        rr_pick = SW'(i);
      end
    end
    rr_found = (rr_best < N);
  end

  // The output register can take a new beat when empty or being drained.
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == LOCK && out_free) ? grant_oh : '0;
  assign accept   = |(in_valid & in_ready);

  // Next-state: arbitration in IDLE, beat transfer and packet end in LOCK.
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    pkt_d       = pkt_q;

    // Drain first; a same-cycle accept below overwrites with no bubble.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!mode && fix_ok) begin
          g_d     = sel;
          state_d = LOCK;
        end else if (mode && rr_found) begin
          g_d     = rr_pick;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (accept) begin
          data_d      = g_data;
          out_last_d  = g_last;
          out_sel_d   = g_q;
          out_valid_d = 1'b1;
          if (g_last) begin
            state_d = IDLE;
            ptr_d   = g_q;
            pkt_d   = pkt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; ptr resets to N-1 so the first search hits 0.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      g_q         <= '0;
      ptr_q       <= SW'(N - 1);
      data_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      pkt_q       <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      ptr_q       <= ptr_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      pkt_q       <= pkt_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign pkt_count = pkt_q;

endmodule
